tone_player: RTL and testbench

//  Parametrised square-wave tone generator for the game's piezo/amp output. Accepts one note
//  per valid/ready handshake (half-period, duration, mode), plays it for a timed duration,

---
 rtl/tone_pkg.sv | 22 ++
 rtl/tick_prescaler.sv | 33 +++
 rtl/tone_player.sv | 175 +++++++++++++++++
 tb/tb_tone_player.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared constants for the tone player: FSM state encodings, note mode
// values and the clock-to-tick divider calculation.
package tone_pkg;

  typedef logic [1:0] tone_state_t;

  localparam tone_state_t ST_IDLE = 2'd0;
  localparam tone_state_t ST_PLAY = 2'd1;
  localparam tone_state_t ST_GAP  = 2'd2;

  localparam logic MODE_STEADY = 1'b0;
  localparam logic MODE_SIREN  = 1'b1;

  // Number of clk cycles per duration tick, never less than one.
  function automatic int tick_div(input int clk_hz, input int tick_hz);
    int d;
    d = clk_hz / tick_hz;
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Duration time base: pulses tick for one clk every CLK_HZ/TICK_HZ cycles.
// restart zeroes the phase so the first tick lands a full interval later.
module tick_prescaler
  import tone_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int DIV = tick_div(CLK_HZ, TICK_HZ);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  // Free-running divider, realigned whenever a note is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tone_player.sv
// Square-wave tone generator: accepts a note over a valid/ready handshake,
// plays it for req_dur ticks, holds a silent gap of GAP_TK ticks, then
// pulses done. Optional siren mode is built only when TONE_SIREN_EN is
// defined; the default build plays every note as a steady tone.
//
// Handshake: a note is taken on any rising clk edge where req_valid and
// req_ready are both high; req_ready is high exactly while in IDLE, so the
// done cycle can also accept the next note.
module tone_player
  import tone_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int DIV_W    = 18,
  parameter int DUR_W    = 12,
  parameter int GAP_TK   = 20,
  parameter int SIREN_TK = 250
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DIV_W-1:0] req_period,
  input  logic [DUR_W-1:0] req_dur,
  input  logic             req_mode,
  input  logic             abort,
  output logic             speaker,
  output logic             gain,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  tone_state_t      state;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] half_cnt;
  logic [DIV_W-1:0] reload;
  logic [DUR_W-1:0] dur_q;
  logic [DUR_W-1:0] tick_cnt;
  logic             tick;
  logic             accept;

  assign accept    = req_valid && (state == ST_IDLE);
  assign req_ready = (state == ST_IDLE);
  assign busy      = ~req_ready;
  assign en        = (state != ST_IDLE);
  assign gain      = (state == ST_PLAY) && (period_q != '0);
  assign state_dbg = state;

  tick_prescaler #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(accept),
    .tick   (tick)
  );

`ifdef TONE_SIREN_EN
  localparam int SIR_W = (SIREN_TK > 1) ? $clog2(SIREN_TK) : 1;

  logic             mode_q;
  logic             phase;
  logic [SIR_W-1:0] sir_cnt;
  logic [DIV_W:0]   alt_sum;
  logic [DIV_W-1:0] alt_half;

  // Alternate half-period is P + P/2, clamped to the largest DIV_W value.
  assign alt_sum  = {1'b0, period_q} + {2'b00, period_q[DIV_W-1:1]};
  assign alt_half = alt_sum[DIV_W] ? '1 : alt_sum[DIV_W-1:0];
  assign reload   = ((mode_q == MODE_SIREN) && phase) ? alt_half : period_q;

  // Siren phase flips every SIREN_TK ticks of play, starting on the base period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_STEADY;
      phase   <= 1'b0;
      sir_cnt <= '0;
    end else if (accept) begin
      mode_q  <= req_mode;
      phase   <= 1'b0;
      sir_cnt <= '0;
    end else if ((state == ST_PLAY) && tick) begin
      if (sir_cnt == SIR_W'(SIREN_TK - 1)) begin
        sir_cnt <= '0;
        phase   <= ~phase;
      end else begin
        sir_cnt <= sir_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_mode;
  localparam int unused_siren_tk = SIREN_TK;
  assign unused_mode = req_mode;
  assign reload      = period_q;
`endif

  // Note FSM with the half-wave generator and the shared duration/gap tick counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      period_q <= '0;
      dur_q    <= '0;
      half_cnt <= '0;
      tick_cnt <= '0;
      speaker  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            period_q <= req_period;
            dur_q    <= req_dur;
            speaker  <= 1'b0;
            tick_cnt <= '0;
            half_cnt <= (req_period == '0) ? '0 : req_period - 1'b1;
            if (req_dur != '0) state <= ST_PLAY;
            else               done  <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (abort) begin
            state   <= ST_IDLE;
            speaker <= 1'b0;
          end else begin
            if (period_q != '0) begin
              if (half_cnt == '0) begin
                speaker  <= ~speaker;
                half_cnt <= reload - 1'b1;
              end else begin
                half_cnt <= half_cnt - 1'b1;
              end
            end
            if (tick) begin
              if (tick_cnt == dur_q - 1'b1) begin
                tick_cnt <= '0;
                speaker  <= 1'b0;
                if (GAP_TK == 0) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
                end else begin
                  state <= ST_GAP;
                end
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
          end
        end
        ST_GAP: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (tick) begin
            if (tick_cnt == DUR_W'(GAP_TK - 1)) begin
              tick_cnt <= '0;
              state    <= ST_IDLE;
              done     <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          speaker <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_player.sv
// Directed bench for tone_player with a 10-clk tick, 2-tick gap and 3-tick
// siren interval. Siren cases follow TONE_SIREN_EN; without it mode=1 notes
// must play as steady tones.
module tb_tone_player;

  localparam int DIV_W   = 8;
  localparam int DUR_W   = 12;
  localparam int TICK_CK = 10;
  localparam int GAP_TK  = 2;
  localparam int GAP_CK  = GAP_TK * TICK_CK;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [DIV_W-1:0] req_period = '0;
  logic [DUR_W-1:0] req_dur = '0;
  logic             req_mode = 1'b0;
  logic             abort = 1'b0;
  logic             speaker, gain, en, busy, done;
  logic [1:0]       state_dbg;

  tone_player #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .DIV_W   (DIV_W),
    .DUR_W   (DUR_W),
    .GAP_TK  (GAP_TK),
    .SIREN_TK(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_period(req_period),
    .req_dur   (req_dur),
    .req_mode  (req_mode),
    .abort     (abort),
    .speaker   (speaker),
    .gain      (gain),
    .en        (en),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // scoreboard: cycle offsets (after the accept edge) where speaker toggles
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_steady(input int p, input int play_len);
    exp_q.delete();
    if (p > 0)
      for (int t = p; t < play_len; t += p) exp_q.push_back(16'(t));
  endtask

  // driver: present a note at negedge, drop valid just after the accept edge
  task automatic send(input string tag, input int p, input int d, input logic m);
    @(negedge clk);
    check({tag, "_ready"}, req_ready, 1);
    req_valid  = 1'b1;
    req_period = DIV_W'(p);
    req_dur    = DUR_W'(d);
    req_mode   = m;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // compare every cycle of a note against the expected waveform and timing
  task automatic observe(input string tag, input int period, input int play_len, input int extra);
    int total, spk_err, gain_err, en_err, done_err, ready_err, n, exp_spk;
    logic in_play, in_gap;
    total = play_len + GAP_CK;
    spk_err = 0; gain_err = 0; en_err = 0; done_err = 0; ready_err = 0;
    for (int k = 0; k <= total + extra; k++) begin
      @(negedge clk);
      in_play = (k < play_len);
      in_gap  = (k >= play_len) && (k < total);
      n = 0;
      foreach (exp_q[i]) if (int'(exp_q[i]) <= k) n++;
      exp_spk = in_play ? (n % 2) : 0;
      if (speaker !== exp_spk[0]) spk_err++;
      if (gain !== (in_play && period != 0)) gain_err++;
      if (en !== (in_play || in_gap)) en_err++;
      if (done !== (k == total)) done_err++;
      if (req_ready !== !(in_play || in_gap)) ready_err++;
    end
    check({tag, "_wave_err"}, spk_err, 0);
    check({tag, "_gain_err"}, gain_err, 0);
    check({tag, "_en_err"}, en_err, 0);
    check({tag, "_done_err"}, done_err, 0);
    check({tag, "_ready_err"}, ready_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    // reset state
    #12;
    check("rst_speaker", speaker, 0);
    check("rst_en", en, 0);
    check("rst_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_gain", gain, 0);
    check("idle_state", state_dbg, 0);

    // 1: steady tone period 4 for 3 ticks
    send("t1", 4, 3, 1'b0);
    fill_steady(4, 30);
    observe("t1", 4, 30, 2);

    // 2: rest note
    send("t2", 0, 2, 1'b0);
    exp_q.delete();
    observe("t2", 0, 20, 2);

    // 3: zero duration note, done the next cycle without playing
    send("t3", 5, 0, 1'b0);
    @(negedge clk);
    check("t3_done", done, 1);
    check("t3_en", en, 0);
    check("t3_ready", req_ready, 1);
    @(negedge clk);
    check("t3_done_clear", done, 0);

    // 4: abort 15 clk into a note, never a done pulse
    send("t4", 4, 5, 1'b0);
    for (int k = 0; k < 15; k++) @(negedge clk);
    check("t4_pre_spk", speaker, 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("t4_spk", speaker, 0);
    check("t4_en", en, 0);
    check("t4_gain", gain, 0);
    check("t4_ready", req_ready, 1);
    dn = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("t4_no_done", dn, 0);

    // abort together with a request in IDLE: request wins
    abort = 1'b1;
    send("t4b", 4, 1, 1'b0);
    abort = 1'b0;
    fill_steady(4, 10);
    observe("t4b", 4, 10, 2);

    // 5: back-to-back note accepted in the done cycle
    send("t5a", 4, 1, 1'b0);
    req_valid  = 1'b1;
    req_period = DIV_W'(6);
    req_dur    = DUR_W'(2);
    req_mode   = 1'b0;
    fill_steady(4, 10);
    observe("t5a", 4, 10, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    fill_steady(6, 20);
    observe("t5b", 6, 20, 2);

    // 6: siren alternation (steady when siren is not built)
    send("t6", 4, 9, 1'b1);
`ifdef TONE_SIREN_EN
    exp_q.delete();
    for (int t = 4; t <= 32; t += 4) exp_q.push_back(16'(t));
    for (int t = 38; t <= 62; t += 6) exp_q.push_back(16'(t));
    for (int t = 66; t <= 86; t += 4) exp_q.push_back(16'(t));
`else
    fill_steady(4, 90);
`endif
    observe("t6", 4, 90, 2);

    // 6b: alternate half-period 180+90 clamps to 255
    send("t6b", 180, 50, 1'b1);
`ifdef TONE_SIREN_EN
    exp_q.delete();
    exp_q.push_back(16'd180);
    exp_q.push_back(16'd435);
`else
    fill_steady(180, 500);
`endif
    observe("t6b", 180, 500, 2);

    // reset in the middle of a note
    send("t7", 4, 5, 1'b0);
    for (int k = 0; k < 15; k++) @(negedge clk);
    check("t7_pre_en", en, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t7_spk", speaker, 0);
    check("t7_en", en, 0);
    check("t7_busy", busy, 0);
    check("t7_ready", req_ready, 1);
    check("t7_state", state_dbg, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t7_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
